// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory load/store path: access sizes,
// load/store FSM states and the default data-memory depth.
package mips_mem_pkg;

    localparam int DM_DEPTH = 512;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_RD     = 3'd1,
        LSU_RMW_RD = 3'd2,
        LSU_RMW_WR = 3'd3,
        LSU_WR     = 3'd4,
        LSU_DONE   = 3'd5
    } lsu_state_e;

    // Size code 3 behaves as a full word, so any code with bit 1 set is a word
    function automatic logic is_word_size(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Big-endian lane logic: extracts and extends a byte/half from a memory word
// for loads, and splices store data into a word for read-modify-write.
module mips_lsu_lane
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [15:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and merge; byte 0 / half 0 sit in the most significant bits
    always_comb begin
        byte_s     = 8'd0;
        half_s     = 16'd0;
        load_data  = word_in;
        merge_data = word_in;

        case (addr_lo)
            2'd0:    byte_s = word_in[31:24];
            2'd1:    byte_s = word_in[23:16];
            2'd2:    byte_s = word_in[15:8];
            2'd3:    byte_s = word_in[7:0];
            default: byte_s = 8'd0;
        endcase

        if (addr_lo[1]) begin
            half_s = word_in[15:0];
        end else begin
            half_s = word_in[31:16];
        end

        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
                case (addr_lo)
                    2'd0:    merge_data = {wdata[7:0], word_in[23:0]};
                    2'd1:    merge_data = {word_in[31:24], wdata[7:0], word_in[15:0]};
                    2'd2:    merge_data = {word_in[31:16], wdata[7:0], word_in[7:0]};
                    2'd3:    merge_data = {word_in[31:8], wdata[7:0]};
                    default: merge_data = word_in;
                endcase
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_s[15]}}, half_s};
                if (addr_lo[1]) begin
                    merge_data = {word_in[31:16], wdata};
                end else begin
                    merge_data = {wdata, word_in[15:0]};
                end
            end
            default: begin
                load_data  = word_in;
                merge_data = word_in;
            end
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store unit between EX/MEM and the MIPS data memory; sub-word stores use
// read-modify-write. Optional misalignment trap: MIPS_LSU_MISALIGN_TRAP_EN.
module mips_load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall,
    output logic [31:0] dm_address,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    input  logic [31:0] dm_read_data
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    lsu_state_e  state_r, next_s;
    logic        accept_s;
    logic        trap_s;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [15:0] wdata_r;
    logic [31:0] load_data_s;
    logic [31:0] merge_data_s;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] dm_address_r;
    logic [31:0] dm_write_data_r;
    logic        dm_mem_write_r;
    logic        dm_mem_read_r;
    logic        unused_addr_s;

    assign accept_s      = req_valid && (state_r == LSU_IDLE);
    assign unused_addr_s = ^req_addr[31:AW+2];

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    logic misalign_r;
    assign trap_s   = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word_size(req_size) && (req_addr[1:0] != 2'b00));
    assign misalign = misalign_r;

    // Misalign flag is raised in the same DONE cycle as the trapped response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= accept_s && trap_s;
        end
    end
`else
    assign trap_s = 1'b0;
`endif

    mips_lsu_lane u_lane (
        .word_in    (dm_read_data),
        .wdata      (wdata_r),
        .addr_lo    (addr_lo_r),
        .size       (size_r),
        .sign_ext   (signed_r),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (!req_valid) begin
                    next_s = LSU_IDLE;
                end else if (trap_s) begin
                    next_s = LSU_DONE;
                end else if (!req_write) begin
                    next_s = LSU_RD;
                end else if (is_word_size(req_size)) begin
                    next_s = LSU_WR;
                end else begin
                    next_s = LSU_RMW_RD;
                end
            end
            LSU_RD:     next_s = LSU_DONE;
            LSU_RMW_RD: next_s = LSU_RMW_WR;
            LSU_RMW_WR: next_s = LSU_DONE;
            LSU_WR:     next_s = LSU_DONE;
            LSU_DONE:   next_s = LSU_IDLE;
            default:    next_s = LSU_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_lo_r <= 2'd0;
            size_r    <= 2'd0;
            signed_r  <= 1'b0;
            wdata_r   <= 16'd0;
        end else if (accept_s) begin
            addr_lo_r <= req_addr[1:0];
            size_r    <= req_size;
            signed_r  <= req_signed;
            wdata_r   <= req_wdata[15:0];
        end
    end

    // Strobes and handshake are registered from the next state so they line up with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            dm_mem_read_r  <= 1'b0;
            dm_mem_write_r <= 1'b0;
        end else begin
            req_ready_r    <= (next_s == LSU_IDLE);
            resp_valid_r   <= (next_s == LSU_DONE);
            dm_mem_read_r  <= (next_s == LSU_RD) || (next_s == LSU_RMW_RD);
            dm_mem_write_r <= (next_s == LSU_WR) || (next_s == LSU_RMW_WR);
        end
    end

    // Address, write data and load result; the memory word is sampled leaving RD/RMW_RD
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dm_address_r    <= 32'd0;
            dm_write_data_r <= 32'd0;
            resp_rdata_r    <= 32'd0;
        end else begin
            if (accept_s) begin
                dm_address_r <= {{(32-AW){1'b0}}, req_addr[AW+1:2]};
            end else begin
                dm_address_r <= dm_address_r;
            end

            if (accept_s && req_write && is_word_size(req_size) && !trap_s) begin
                dm_write_data_r <= req_wdata;
            end else if (state_r == LSU_RMW_RD) begin
                dm_write_data_r <= merge_data_s;
            end else begin
                dm_write_data_r <= dm_write_data_r;
            end

            if (state_r == LSU_RD) begin
                resp_rdata_r <= load_data_s;
            end else if (next_s == LSU_DONE) begin
                resp_rdata_r <= 32'd0;
            end else begin
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = resp_rdata_r;
    assign dm_address    = dm_address_r;
    assign dm_write_data = dm_write_data_r;
    assign dm_mem_write  = dm_mem_write_r;
    assign dm_mem_read   = dm_mem_read_r;
    assign stall         = (state_r != LSU_IDLE) || req_valid;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Scoreboard bench for mips_load_store_unit with a falling-edge-read data memory model.
// Exercises the misalignment trap when MIPS_LSU_MISALIGN_TRAP_EN is defined.
module tb_mips_load_store_unit;
    import mips_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, stall;
    logic [31:0] resp_rdata;
    logic [31:0] dm_address, dm_write_data;
    logic        dm_mem_write, dm_mem_read;
    logic [31:0] dm_read_data = 32'd0;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clock = ~clock;

    mips_load_store_unit dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .stall         (stall),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_mem_write  (dm_mem_write),
        .dm_mem_read   (dm_mem_read),
        .dm_read_data  (dm_read_data)
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign)
`endif
    );

    // Data memory model: read data registered on the falling edge, writes on the rising edge
    logic [31:0] mem [0:511];
    always @(negedge clock) if (dm_mem_read) dm_read_data <= mem[dm_address[8:0]];
    always @(posedge clock) if (dm_mem_write) mem[dm_address[8:0]] <= dm_write_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   ncyc = 0, acc_cyc = 0, rd_cnt = 0, wr_cnt = 0, wr_total = 0, last_done = 0;

    // Monitor: strobe checks every cycle, response checks against the scoreboard head
    always @(negedge clock) begin
        ncyc++;
        if (!reset) begin
            if (dm_mem_read || dm_mem_write) begin
                chk("strobe_excl", 32'(dm_mem_read & dm_mem_write), 32'd0);
                if (exp_q.size() > 0) chk("dm_address", dm_address, exp_q[0].addr);
            end
            if (dm_mem_read) rd_cnt++;
            if (dm_mem_write) begin
                wr_cnt++;
                wr_total++;
                if (exp_q.size() > 0) chk("dm_write_data", dm_write_data, exp_q[0].wdata);
            end
            if (resp_valid) begin
                last_done = ncyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", 32'(ncyc - acc_cyc), 32'(e.lat));
                    chk("read_strobes", 32'(rd_cnt), 32'(e.nrd));
                    chk("write_strobes", 32'(wr_cnt), 32'(e.nwr));
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
                    chk("misalign", 32'(misalign), 32'(e.mis));
`endif
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = ncyc;
                rd_cnt  = 0;
                wr_cnt  = 0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int lat, input int nrd,
                         input int nwr, input logic [31:0] exp_wd, input logic mis);
        exp_t x;
        x.rdata = exp_rd;
        x.lat   = lat;
        x.nrd   = nrd;
        x.nwr   = nwr;
        x.addr  = (a >> 2) & 32'h0000_01FF;
        x.wdata = exp_wd;
        x.mis   = mis;
        exp_q.push_back(x);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = req_ready;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input int lat, input int nrd,
                      input int nwr, input logic [31:0] exp_wd, input logic mis);
        issue(wr, sz, sg, a, wd, exp_rd, lat, nrd, nwr, exp_wd, mis);
        wait_accept();
        req_valid = 1'b0;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int acc_a, done_a, acc_b, wt;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_read", 32'(dm_mem_read), 32'd0);
        chk("rst_mem_write", 32'(dm_mem_write), 32'd0);
        chk("rst_address", dm_address, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Preload through word stores
        op(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h0000_0007, 32'd0, 2, 0, 1, 32'h0000_0007, 1'b0);
        op(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h80FF_1234, 32'd0, 2, 0, 1, 32'h80FF_1234, 1'b0);
        op(1'b1, SZ_WORD, 1'b0, 32'h0C, 32'h1122_3344, 32'd0, 2, 0, 1, 32'h1122_3344, 1'b0);

        // Loads with lane select and extension
        op(1'b0, SZ_WORD, 1'b0, 32'h14, 32'd0, 32'h0000_0007, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_BYTE, 1'b1, 32'h08, 32'd0, 32'hFFFF_FF80, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_BYTE, 1'b0, 32'h08, 32'd0, 32'h0000_0080, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'd0, 32'hFFFF_FFFF, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_HALF, 1'b1, 32'h08, 32'd0, 32'hFFFF_80FF, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'd0, 32'h0000_1234, 2, 1, 0, 32'd0, 1'b0);

        // Sub-word stores via read-modify-write
        op(1'b1, SZ_BYTE, 1'b0, 32'h0E, 32'hFFFF_FFAB, 32'd0, 3, 1, 1, 32'h1122_AB44, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'd0, 32'h1122_AB44, 2, 1, 0, 32'd0, 1'b0);
        op(1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h0000_5678, 32'd0, 3, 1, 1, 32'h80FF_5678, 1'b0);

        // Address wrap modulo DEPTH
        op(1'b1, SZ_WORD, 1'b0, 32'h804, 32'hDEAD_BEEF, 32'd0, 2, 0, 1, 32'hDEAD_BEEF, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h04, 32'd0, 32'hDEAD_BEEF, 2, 1, 0, 32'd0, 1'b0);

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        op(1'b0, SZ_WORD, 1'b0, 32'h15, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1'b1);
        op(1'b0, SZ_HALF, 1'b1, 32'h09, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1'b1);
        op(1'b1, SZ_WORD, 1'b0, 32'h16, 32'h1234_5678, 32'd0, 1, 0, 0, 32'd0, 1'b1);
`else
        op(1'b0, SZ_WORD, 1'b0, 32'h15, 32'd0, 32'h0000_0007, 2, 1, 0, 32'd0, 1'b0);
        op(1'b0, SZ_HALF, 1'b1, 32'h09, 32'd0, 32'hFFFF_80FF, 2, 1, 0, 32'd0, 1'b0);
`endif

        // Back-to-back requests with req_valid held high
        issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'd0, 32'h80FF_5678, 2, 1, 0, 32'd0, 1'b0);
        wait_accept();
        acc_a = acc_cyc;
        issue(1'b0, SZ_BYTE, 1'b0, 32'h0B, 32'd0, 32'h0000_0078, 2, 1, 0, 32'd0, 1'b0);
        wait_accept();
        acc_b  = acc_cyc;
        done_a = last_done;
        req_valid = 1'b0;
        drain();
        chk("b2b_after_done", 32'(acc_b), 32'(done_a + 1));
        chk("b2b_spacing", 32'(acc_b - acc_a), 32'd3);

        // Reset in the middle of a read-modify-write
        issue(1'b1, SZ_BYTE, 1'b0, 32'h0C, 32'h0000_0055, 32'd0, 3, 1, 1, 32'h5522_AB44, 1'b0);
        wait_accept();
        chk("rmw_rd_strobe", 32'(dm_mem_read), 32'd1);
        wt = wr_total;
        reset = 1'b1;
        #1;
        chk("abort_mem_read", 32'(dm_mem_read), 32'd0);
        chk("abort_mem_write", 32'(dm_mem_write), 32'd0);
        chk("abort_address", dm_address, 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("abort_no_write", 32'(wr_total), 32'(wt));
        chk("abort_mem_kept", mem[3], 32'h1122_AB44);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        op(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'd0, 32'h1122_AB44, 2, 1, 0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
